// File: rtl/fade_ramp_gen.sv
// fade_ramp_gen: triangle-wave "breathing" duty sequencer for a downstream PWM stage.
// A prescaler turns clk into ticks. On each tick, a four-state FSM ramps the duty
// value up to MAX_VAL, holds, ramps down to MIN_VAL, and holds again. Every duty
// update is published as a one-cycle value_wr strobe.
`timescale 1ns/1ps
module fade_ramp_gen #(
    parameter int unsigned PERIOD     = 262144,
    parameter int unsigned MIN_VAL    = 0,
    parameter int unsigned MAX_VAL    = 128,
    parameter int unsigned STEP       = 1,
    parameter int unsigned HOLD_TICKS = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       run,
    input  logic [1:0] speed,
    output logic [7:0] value_out,
    output logic       value_wr,
    output logic       dir_up,
    output logic       at_peak
);

    localparam int unsigned CW        = $clog2(PERIOD + 1);
    localparam int unsigned HW        = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam bit          NO_HOLD   = (HOLD_TICKS == 0);
    localparam logic [8:0]  MIN9      = 9'(MIN_VAL);
    localparam logic [8:0]  MAX9      = 9'(MAX_VAL);
    localparam logic [8:0]  STEP9     = 9'(STEP);
    localparam logic [7:0]  MIN8      = 8'(MIN_VAL);
    localparam logic [7:0]  MAX8      = 8'(MAX_VAL);
    localparam logic [7:0]  STEP8     = 8'(STEP);
    localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_TICKS - 1);

    typedef enum logic [1:0] {RISE, HOLD_HI, FALL, HOLD_LO} state_t;

    state_t          state, state_n;
    logic [CW-1:0]   count, count_n;
    logic [CW-1:0]   limit;
    logic            tick;
    logic [HW-1:0]   hold_cnt, hold_n;
    logic            init_pending, init_n;
    logic [7:0]      value_n;
    logic            wr_n;
    logic            dir_n;
    logic            peak_n;
    logic [8:0]      sum;

    // Prescaler compare: >= lets a shortened limit tick immediately without wrapping.
    always_comb begin
        limit = CW'(PERIOD >> speed);
        tick  = run && (count >= (limit - CW'(1)));
    end

    // Next-state, duty arithmetic and strobe generation; init write beats a coincident tick.
    always_comb begin
        state_n = state;
        count_n = count;
        hold_n  = hold_cnt;
        init_n  = init_pending;
        value_n = value_out;
        wr_n    = 1'b0;
        sum     = {1'b0, value_out} + STEP9;

        if (run) begin
            count_n = tick ? '0 : count + CW'(1);
        end

        if (init_pending) begin
            init_n  = 1'b0;
            wr_n    = 1'b1;
            value_n = MIN8;
        end else if (tick) begin
            unique case (state)
                RISE: begin
                    wr_n = 1'b1;
                    if (sum >= MAX9) begin
                        value_n = MAX8;
                        state_n = NO_HOLD ? FALL : HOLD_HI;
                        hold_n  = '0;
                    end else begin
                        value_n = sum[7:0];
                    end
                end
                HOLD_HI: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = FALL;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
                FALL: begin
                    wr_n = 1'b1;
                    if ({1'b0, value_out} <= (MIN9 + STEP9)) begin
                        value_n = MIN8;
                        state_n = NO_HOLD ? RISE : HOLD_LO;
                        hold_n  = '0;
                    end else begin
                        value_n = value_out - STEP8;
                    end
                end
                HOLD_LO: begin
                    if (hold_cnt == HOLD_LAST) begin
                        state_n = RISE;
                    end else begin
                        hold_n = hold_cnt + HW'(1);
                    end
                end
                default: state_n = RISE;
            endcase
        end

        dir_n  = (state_n == RISE) || (state_n == HOLD_HI);
        peak_n = (state_n == HOLD_HI);
    end

    // State, prescaler and registered outputs; reset also cancels any pending strobe.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= RISE;
            count        <= '0;
            hold_cnt     <= '0;
            init_pending <= 1'b1;
            value_out    <= MIN8;
            value_wr     <= 1'b0;
            dir_up       <= 1'b1;
            at_peak      <= 1'b0;
        end else begin
            state        <= state_n;
            count        <= count_n;
            hold_cnt     <= hold_n;
            init_pending <= init_n;
            value_out    <= value_n;
            value_wr     <= wr_n;
            dir_up       <= dir_n;
            at_peak      <= peak_n;
        end
    end

endmodule
